mem_port_arbiter: RTL and testbench

Shares one unified single-port memory between the pipeline's instruction-fetch port and its load/store port.
- Holds at most one transaction outstanding.
- Data requests have priority; a streak counter guarantees fetch forward progress.
- A watchdog aborts requests the memory never answers.
- Sits between riscv_pipeline's instr_*/data_* interfaces (through stall logic) and the memory controller.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/mem_port_arbiter_select.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared state and owner types for the memory port arbiter.
// Latency: none, types only.
// Backpressure: not applicable.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Picks fetch or data: data wins unless fetch has waited through MAX_DATA_STREAK data grants.
// Latency: selection is combinational; the streak counter updates on the grant edge.
// Backpressure: none; the caller samples sel_owner only when it is ready to latch a request.
module arb_select
    import riscv_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       data_gnt,
    input  logic       fetch_gnt,
    output arb_owner_t sel_owner
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    // Data has priority; a saturated streak hands one slot to a waiting fetch.
    always_comb begin
        sel_owner = OWNER_FETCH;
        if (d_req && !(if_req && (streak_q == SMAX))) begin
            sel_owner = OWNER_DATA;
        end
    end

    // Streak counts data grants that happened while fetch was waiting.
    always_comb begin
        streak_d = streak_q;
        if (fetch_gnt) begin
            streak_d = '0;
        end else if (data_gnt) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (streak_q != SMAX) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction outstanding.
// Latency: request in cycle N drives mem_req in N+1; gnt same cycle as mem_ready; rvalid same cycle as mem_rvalid.
// Backpressure: requests are held until gnt; mem_req is held until mem_ready; unanswered requests abort after TIMEOUT_CYCLES.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_we,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, owner_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [TW-1:0]         timer_q, timer_d;

    arb_owner_t sel_owner;
    logic       any_req;
    logic       accept;
    logic       resp_fire;
    logic       tmo_fire;
    logic       load_txn;

    // Event decode; reset masks every pulse so nothing escapes mid-reset.
    always_comb begin
        any_req   = if_req || d_req;
        accept    = !reset && (state_q == ISSUE) && mem_ready;
        resp_fire = !reset && (state_q == WAIT_RESP) && mem_rvalid;
        tmo_fire  = !reset && (state_q == WAIT_RESP) && !mem_rvalid && (timer_q == TMAX);
        load_txn  = any_req && ((state_q == IDLE) || resp_fire);
    end

    arb_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .data_gnt (accept && (owner_q == OWNER_DATA)),
        .fetch_gnt(accept && (owner_q == OWNER_FETCH)),
        .sel_owner(sel_owner)
    );

    // Next-state: issue, wait for response or timeout, re-arbitrate without an idle bubble.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = WAIT_RESP;
                    timer_d = '0;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + TW'(1);
                if (mem_rvalid || (timer_q == TMAX)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_txn) begin
            state_d = ISSUE;
            owner_d = sel_owner;
            if (sel_owner == OWNER_FETCH) begin
                addr_d  = if_addr;
                wdata_d = '0;
                we_d    = 1'b0;
            end else begin
                addr_d  = d_addr;
                wdata_d = d_wdata;
                we_d    = d_we;
            end
        end
    end

    // State and latched transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            timer_q <= timer_d;
        end
    end

    // Outputs: pulses steered to the owner, the non-owner rdata held at zero.
    always_comb begin
        mem_req   = !reset && (state_q == ISSUE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = we_q;
        busy      = (state_q != IDLE);
        if_gnt    = accept && (owner_q == OWNER_FETCH);
        d_gnt     = accept && (owner_q == OWNER_DATA);
        if_rvalid = resp_fire && (owner_q == OWNER_FETCH);
        d_rvalid  = resp_fire && (owner_q == OWNER_DATA);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        if_err    = tmo_fire && (owner_q == OWNER_FETCH);
        d_err     = tmo_fire && (owner_q == OWNER_DATA);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: the bench plays both requesters and the memory, including random mem_ready stalls.
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [DW-1:0] d_addr, d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid, busy;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        d_req = 0; d_addr = '0; d_wdata = '0; d_we = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        step(); step();
        #1;
        total++;
        if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we} !== 8'h00)
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we});
        total++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata});
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we} !== 8'h00) bad++;
        idle_inputs();
        step();
        reset = 0;
        step();
    endtask

    task automatic test_fetch_read();
        int gnt_cnt = 0, rv_cnt = 0, rv_cyc = -1;
        logic [DW-1:0] cap = '0;
        logic d_any = 0;
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            if (k <= 1) begin if_req = 1; if_addr = 32'h100; mem_ready = 1; end
            if (k == 3) begin mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; end
            #1;
            if (k == 0) begin
                total++;
                if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_latency got=%b exp=0", mem_req); end
            end
            if (k == 1) begin
                total++;
                if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
                    bad++;
                    $display("FAIL fetch_issue got=%b/%b/%h exp=1/0/00000100", mem_req, mem_we, mem_addr);
                end
            end
            gnt_cnt += int'(if_gnt);
            rv_cnt  += int'(if_rvalid);
            if (if_rvalid) begin cap = if_rdata; rv_cyc = k; end
            d_any |= d_gnt | d_rvalid | d_err | (d_rdata != '0);
            step();
        end
        total++;
        if (gnt_cnt != 1) begin bad++; $display("FAIL fetch_gnt_count got=%0d exp=1", gnt_cnt); end
        total++;
        if (rv_cnt != 1 || rv_cyc != 3) begin
            bad++; $display("FAIL fetch_rvalid got=%0d@%0d exp=1@3", rv_cnt, rv_cyc);
        end
        total++;
        if (cap !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata got=%h exp=deadbeef", cap); end
        total++;
        if (d_any !== 1'b0) begin bad++; $display("FAIL fetch_d_quiet got=%b exp=0", d_any); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL fetch_busy got=%b exp=0", busy); end
    endtask

    task automatic test_store();
        idle_inputs();
        d_req = 1; d_addr = 32'h2000; d_wdata = 32'h55; d_we = 1; mem_ready = 1;
        step();
        #1;
        total++;
        if ({mem_req, mem_we, mem_wdata, mem_addr, d_gnt, if_gnt} !== {2'b11, 32'h55, 32'h2000, 2'b10}) begin
            bad++;
            $display("FAIL store_issue got=%b/%b/%h/%h/%b%b exp=1/1/00000055/00002000/10",
                     mem_req, mem_we, mem_wdata, mem_addr, d_gnt, if_gnt);
        end
        step();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0;
        #1;
        total++;
        if ({d_rvalid, if_rvalid} !== 2'b10) begin
            bad++; $display("FAIL store_ack got=%b%b exp=10", d_rvalid, if_rvalid);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if ({busy, d_rvalid} !== 2'b00) begin bad++; $display("FAIL store_done got=%b%b exp=00", busy, d_rvalid); end
    endtask

    task automatic test_deassert();
        int stable_bad = 0;
        idle_inputs();
        d_req = 1; d_addr = 32'h500; d_we = 0;
        step();
        d_req = 0; d_addr = 32'h9999;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (!(mem_req === 1'b1 && mem_addr === 32'h500 && d_gnt === 1'b0)) stable_bad++;
            step();
        end
        total++;
        if (stable_bad != 0) begin bad++; $display("FAIL deassert_hold got=%0d exp=0 unstable cycles", stable_bad); end
        mem_ready = 1;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL deassert_gnt got=%b exp=1", d_gnt); end
        step();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0000_0A5A;
        #1;
        total++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_0A5A}) begin
            bad++; $display("FAIL deassert_resp got=%b/%h exp=1/00000a5a", d_rvalid, d_rdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        string got = "";
        int    ngr = 0, b2b_bad = 0;
        bit    last_gnt = 0, last_rv_pend = 0, done;
        for (int k = 0; k < 80; k++) begin
            if_req = (ngr < 10); d_req = (ngr < 10);
            if_addr = 32'h1000; d_addr = 32'h2000; d_we = 0; d_wdata = '0;
            mem_ready = 1; mem_rvalid = last_gnt; mem_rdata = 32'(k);
            #1;
            if (last_rv_pend && mem_req !== 1'b1) b2b_bad++;
            if (d_gnt) got = {got, "D"};
            if (if_gnt) got = {got, "F"};
            ngr += int'(if_gnt) + int'(d_gnt);
            done = mem_rvalid && (ngr >= 10) && !if_req && !d_req;
            last_rv_pend = mem_rvalid && (if_req || d_req);
            last_gnt = if_gnt | d_gnt;
            step();
            if (done) break;
        end
        total++;
        if (got != "DDDDFDDDDF") begin bad++; $display("FAIL grant_order got=%s exp=DDDDFDDDDF", got); end
        total++;
        if (b2b_bad != 0) begin bad++; $display("FAIL back_to_back got=%0d exp=0 bubbles", b2b_bad); end
        idle_inputs();
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        int err_cnt = 0, err_cyc = -1, ierr = 0;
        idle_inputs();
        d_req = 1; d_addr = 32'h300; mem_ready = 1;
        step();
        #1;
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL tmo_gnt got=%b exp=1", d_gnt); end
        step();
        idle_inputs();
        for (int n = 1; n <= 70; n++) begin
            #1;
            if (d_err) begin err_cnt++; if (err_cyc < 0) err_cyc = n; end
            ierr += int'(if_err);
            step();
        end
        total++;
        if (err_cnt != 1 || err_cyc != TMO) begin
            bad++; $display("FAIL tmo_err got=%0d@%0d exp=1@%0d", err_cnt, err_cyc, TMO);
        end
        total++;
        if ({ierr != 0, busy} !== 2'b00) begin bad++; $display("FAIL tmo_state got=%0d/%b exp=0/0", ierr, busy); end
        mem_rvalid = 1; mem_rdata = 32'h1234;
        #1;
        total++;
        if ({d_rvalid, if_rvalid, d_rdata} !== 34'h0) begin
            bad++; $display("FAIL tmo_stray got=%b%b/%h exp=00/0", d_rvalid, if_rvalid, d_rdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        if_req = 1; if_addr = 32'h400; mem_ready = 1;
        step();
        step();
        idle_inputs();
        step();
        reset = 1; mem_rvalid = 1; mem_rdata = 32'h0BAD;
        #1;
        total++;
        if ({if_rvalid, if_gnt, if_err} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_pulse got=%b exp=000", {if_rvalid, if_gnt, if_err});
        end
        step();
        reset = 0;
        #1;
        total++;
        if ({busy, mem_req, if_rvalid, d_rvalid, if_rdata, mem_addr} !== 68'h0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b%b%b%b/%h/%h exp=0", busy, mem_req, if_rvalid, d_rvalid,
                            if_rdata, mem_addr);
        end
        step();
        idle_inputs();
        if_req = 1; if_addr = 32'h440; mem_ready = 1;
        step();
        #1;
        total++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h440}) begin
            bad++; $display("FAIL rst_mid_refetch got=%b/%h exp=1/00000440", if_gnt, mem_addr);
        end
        step();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_0440;
        #1;
        total++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hCAFE_0440}) begin
            bad++; $display("FAIL rst_mid_resp got=%b/%h exp=1/cafe0440", if_rvalid, if_rdata);
        end
        step();
        idle_inputs();
    endtask

    // Transaction-level model: one outstanding access, picked whenever the port is free.
    task automatic test_random();
        int            ph = 0;
        bit            m_data = 0, m_we = 0;
        logic [DW-1:0] m_addr = '0, m_wd = '0;
        int            streak = 0, resp_cnt = 0;
        bit            acc, rv, gen, drop_if, drop_d;
        bit            e_ig, e_dg, e_irv, e_drv;
        reset = 1;
        idle_inputs();
        step();
        reset = 0;
        for (int cyc = 0; cyc < 480; cyc++) begin
            gen = (cyc < 400);
            if (!if_req && gen && ($urandom_range(0, 2) == 0)) begin
                if_req = 1; if_addr = $urandom & 32'h0000_FFFC;
            end
            if (!d_req && gen && ($urandom_range(0, 2) == 0)) begin
                d_req = 1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
            end
            mem_ready  = gen ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rvalid = (resp_cnt == 1);
            mem_rdata  = $urandom;
            #1;
            acc   = (ph == 1) && mem_ready;
            rv    = (ph == 2) && mem_rvalid;
            e_ig  = acc && !m_data;
            e_dg  = acc && m_data;
            e_irv = rv && !m_data;
            e_drv = rv && m_data;
            total++;
            if (mem_req !== (ph == 1)) begin bad++; $display("FAIL rnd_mem_req c%0d got=%b exp=%b", cyc, mem_req, ph == 1); end
            if (ph == 1) begin
                total++;
                if (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wd)) begin
                    bad++;
                    $display("FAIL rnd_mem_bus c%0d got=%h/%b/%h exp=%h/%b/%h", cyc, mem_addr, mem_we, mem_wdata,
                             m_addr, m_we, m_wd);
                end
            end
            total++;
            if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
                bad++; $display("FAIL rnd_gnt c%0d got=%b%b exp=%b%b", cyc, if_gnt, d_gnt, e_ig, e_dg);
            end
            total++;
            if ({if_rvalid, d_rvalid} !== {e_irv, e_drv}) begin
                bad++; $display("FAIL rnd_rvalid c%0d got=%b%b exp=%b%b", cyc, if_rvalid, d_rvalid, e_irv, e_drv);
            end
            total++;
            if (if_rdata !== (e_irv ? mem_rdata : '0) || d_rdata !== (e_drv ? mem_rdata : '0)) begin
                bad++; $display("FAIL rnd_rdata c%0d got=%h/%h in=%h", cyc, if_rdata, d_rdata, mem_rdata);
            end
            total++;
            if ({if_err, d_err, busy} !== {2'b00, ph != 0}) begin
                bad++; $display("FAIL rnd_err_busy c%0d got=%b%b%b exp=00%b", cyc, if_err, d_err, busy, ph != 0);
            end
            drop_if = e_ig;
            drop_d  = e_dg;
            if (resp_cnt > 0) resp_cnt--;
            if (acc) begin
                if (m_data && if_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
                else streak = 0;
                ph = 2;
                resp_cnt = $urandom_range(1, 3);
            end else if (ph == 0 || rv) begin
                if (if_req || d_req) begin
                    m_data = d_req && !(if_req && streak == MAXS);
                    m_addr = m_data ? d_addr : if_addr;
                    m_we   = m_data && d_we;
                    m_wd   = d_wdata;
                    ph = 1;
                end else begin
                    ph = 0;
                end
            end
            step();
            if (drop_if) if_req = 0;
            if (drop_d) d_req = 0;
        end
        total++;
        if (ph != 0 || busy !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%0d/%b exp=0/0", ph, busy); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_deassert();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

endmodule
